// File: rtl/mult_sched.sv
// mult_sched: shares one pipelined 4x4 multiplier among NREQ requesters, tagging each product with its requester ID.
// Define MULT_SCHED_RR_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module mult_sched #(
    parameter int NREQ = 2,
    parameter int LAT  = 2,
    parameter int IDW  = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [4*NREQ-1:0] a_in_i,
    input  logic [4*NREQ-1:0] b_in_i,
    input  logic              hold_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [3:0]        mult_a_o,
    output logic [3:0]        mult_b_o,
    output logic              mult_en_o,
    input  logic [7:0]        mult_y_i,
    output logic              res_valid_o,
    output logic [IDW-1:0]    res_id_o,
    output logic [7:0]        res_y_o,
    output logic              busy_o
);
    localparam int CW = $clog2(LAT + 2);
    localparam int NS = 2 ** IDW;

    logic [NREQ-1:0] ack_q, ack_d;
    logic [3:0]      ma_q, ma_d, mb_q, mb_d;
    logic [LAT:0]    tv_q, tv_d;
    logic [IDW-1:0]  tid_q [LAT+1];
    logic [IDW-1:0]  tid_d [LAT+1];
    logic            rv_q, rv_d;
    logic [IDW-1:0]  rid_q, rid_d;
    logic [7:0]      ry_q, ry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NS-1:0]   elig;
    logic [3:0]      a_arr [NS];
    logic [3:0]      b_arr [NS];
    logic [IDW-1:0]  gid, idx, base;
    logic            found, issue, retire;

`ifdef MULT_SCHED_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;
    assign base  = ptr_q;
    assign ptr_d = issue ? IDW'((int'(gid) + 1) % NREQ) : ptr_q;
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) ptr_q <= '0;
        else ptr_q <= ptr_d;
`else
    assign base = '0;
`endif

    // A requester acked last cycle sits out one cycle so it can update or drop its request.
    always_comb begin
        elig = '0;
        elig[NREQ-1:0] = req_i & ~ack_q;
        found = 1'b0;
        gid = '0;
        idx = '0;
        for (int i = 0; i < NS; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = a_in_i[4*i +: 4];
            b_arr[i] = b_in_i[4*i +: 4];
        end
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(base) + i) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gid = idx;
            end
        end
    end

    assign issue  = !hold_i && found;
    assign retire = !hold_i && tv_q[LAT];

    always_comb begin
        ack_d = issue ? NREQ'(1) << gid : '0;
        ma_d  = issue ? a_arr[gid] : ma_q;
        mb_d  = issue ? b_arr[gid] : mb_q;
        tv_d  = hold_i ? tv_q : {tv_q[LAT-1:0], found};
        tid_d[0] = hold_i ? tid_q[0] : gid;
        for (int i = 1; i <= LAT; i++) tid_d[i] = hold_i ? tid_q[i] : tid_q[i-1];
        rv_d  = retire;
        rid_d = retire ? tid_q[LAT] : rid_q;
        ry_d  = retire ? mult_y_i : ry_q;
        cnt_d = cnt_q + CW'(issue) - CW'(retire);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ack_q <= '0;
            ma_q  <= '0;
            mb_q  <= '0;
            tv_q  <= '0;
            for (int i = 0; i <= LAT; i++) tid_q[i] <= '0;
            rv_q  <= 1'b0;
            rid_q <= '0;
            ry_q  <= '0;
            cnt_q <= '0;
        end else begin
            ack_q <= ack_d;
            ma_q  <= ma_d;
            mb_q  <= mb_d;
            tv_q  <= tv_d;
            for (int i = 0; i <= LAT; i++) tid_q[i] <= tid_d[i];
            rv_q  <= rv_d;
            rid_q <= rid_d;
            ry_q  <= ry_d;
            cnt_q <= cnt_d;
        end
    end

    assign ack_o       = ack_q;
    assign mult_a_o    = ma_q;
    assign mult_b_o    = mb_q;
    assign mult_en_o   = ~hold_i;
    assign res_valid_o = rv_q;
    assign res_id_o    = rid_q;
    assign res_y_o     = ry_q;
    assign busy_o      = cnt_q != '0;
endmodule

// File: doc/mult_sched.md
# mult_sched

Round-robin scheduler that shares one pipelined 4x4 multiplier (`pipeline_multiplier`) between NREQ requesters. Each requester presents operands with a request line. The block grants one requester per cycle and drives the multiplier's operand and enable inputs. A tag for each operation travels alongside the multiplier pipeline, so every product is returned labelled with the ID of the requester that issued it. The block sits between requester logic (switch/sequencer front-ends) and the `pipeline_multiplier` instance, replacing direct board-input wiring.

## Interface
- NREQ, 2: number of requesters, 2..4.
- LAT, 2: multiplier latency in enabled cycles from operand capture to valid `mult_y`. Must equal the pipeline depth of the attached multiplier.
- IDW, 2: width of the requester ID; must satisfy 2^IDW >= NREQ.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held high with operands until the matching ack.
- a_in  in  4*NREQ  operand A, requester i at [4i+3:4i].
- b_in  in  4*NREQ  operand B, same packing.
- hold  in  1  stall; freezes the scheduler and the multiplier.
- ack  out  NREQ  one-hot grant pulse, registered.
- mult_a  out  4  operand A to the multiplier, registered.
- mult_b  out  4  operand B to the multiplier, registered.
- mult_en  out  1  multiplier EN, equal to ~hold.
- mult_y  in  8  product from the multiplier.
- res_valid  out  1  result strobe, registered.
- res_id  out  IDW  requester ID of the result.
- res_y  out  8  product.
- busy  out  1  high when any operation is in flight.

## Operation
- Reset values: ack=0, mult_a=0, mult_b=0, res_valid=0, res_id=0, res_y=0, busy=0. The tag pipe clears, the in-flight count clears and the round-robin pointer resets to 0. `mult_en` follows `~hold` even during reset.
- Eligible set: `req & ~ack`. A requester that was acked in the previous cycle is excluded for one cycle so it can update or drop its request. Per-requester throughput is therefore at most one operation every 2 cycles; aggregate throughput is 1 per cycle when NREQ >= 2 requesters are active.
- Arbitration at each edge with hold=0:
  - If the eligible set is non-empty, grant the first eligible requester at or after pointer `ptr`, searching upward with wrap.
  - Register `ack[g]=1`, `mult_a=a_in[g]`, `mult_b=b_in[g]`, and push tag {valid=1, id=g} into the tag pipe.
  - Set `ptr` to g+1 modulo NREQ.
  - If the eligible set is empty, set ack=0, push tag valid=0, and leave `mult_a`/`mult_b` unchanged.
- Tag pipe: LAT+1 stages, shifting only when hold=0. The output stage lines up with `mult_y`.
- Result stage: when the tag pipe output is valid and hold=0, register res_valid=1, res_id=tag id, res_y=mult_y. Otherwise res_valid=0 and res_id/res_y hold their values.
- In-flight count: width covers 0..LAT+1. It increments on issue and decrements on res_valid; simultaneous issue and retire leave it unchanged. busy = (count != 0).
- Hold: while hold=1 there are no grants, ack=0, res_valid=0, and the tag pipe, pointer, count and operand registers are frozen. Work resumes exactly where it stopped when hold falls.
- Reset mid-operation: all in-flight operations are discarded and no res_valid is produced for them.

## Timing
- Edge k samples `req[i]` and grants it. After edge k: ack[i]=1 for exactly 1 cycle, and `mult_a`/`mult_b` are valid.
- The product appears on `mult_y` after edge k+LAT. res_valid is high for 1 cycle after edge k+LAT+1.
- Issue-to-result latency is LAT+1 cycles, plus one cycle for each hold cycle in between.
- A requester may change operands or drop `req` in the cycle ack is high. A `req` dropped before ack is granted cancels the request with no side effects.

## Configuration
- MULT_SCHED_RR_EN defined: round-robin arbitration as described above.
- MULT_SCHED_RR_EN undefined: fixed priority, lowest eligible index wins; `ptr` is removed. The ack-exclusion rule still applies.

## Test plan
- Single request: NREQ=2, LAT=2, req[0] with a=3, b=5, sampled at edge 0. Required: ack[0] after edge 0; res_valid=1, res_id=0, res_y=0x0F after edge 3; busy high from edge 0 until after edge 3.
- Both requesters held continuously: req0 a=2 b=7, req1 a=9 b=9. Required: acks alternate 0,1,0,1 on consecutive cycles; results 0x0E (id 0) and 0x51 (id 1) alternate in the same order, one per cycle.
- Hold mid-flight: issue 0xF*0xF, then assert hold for 3 cycles right after the grant. Required: no ack and no res_valid during hold; res_y=0xE1 appears 3 cycles later than the unstalled case.
- Reset with 2 operations in flight. Required: all outputs 0 immediately (asynchronous); no res_valid afterwards; a new request after reset is granted with ptr=0 priority.
- Priority check: req[1] alone, then req[0] and req[1] together. Required: with MULT_SCHED_RR_EN, requester 0 wins the second grant; without it, requester 0 also wins, and a continuously held req[1] starves only until the exclusion cycle lets it through.
